// File: rtl/timer_apb_pkg.sv
// rtl/timer_apb_pkg.sv - shared types and constants for the timer APB requester
//
// Purpose : FSM state encoding, default bus widths and the word-alignment
//           mask used by timer_apb_master and its helpers.
// Ports   : none (package).
package timer_apb_pkg;

  localparam int unsigned APB_ADDR_W_DEF = 13;
  localparam int unsigned APB_DATA_W_DEF = 32;

  // Low address bits that must be zero for a 32-bit word access.
  localparam logic [1:0] APB_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  function automatic logic addr_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & APB_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/timer_apb_mst_timeout.sv
// rtl/timer_apb_mst_timeout.sv - saturating wait-state counter with expiry flag
//
// Purpose : counts ACCESS cycles spent waiting for PREADY and flags the cycle
//           in which the LIMIT-th consecutive wait cycle is reached.
// Ports   : clk      - clock
//           rst      - asynchronous active-high reset
//           clear    - restart the count (asserted the cycle before ACCESS)
//           count_en - this cycle is an ACCESS cycle with pready low
//           expired  - current wait cycle is the LIMIT-th one
module timer_apb_mst_timeout #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  // Holds at LAST so a stalled ACCESS cannot wrap and miss the expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Gated by count_en so a pready in the final cycle takes precedence.
  assign expired = count_en && (cnt == LAST);

endmodule

// File: rtl/timer_apb_master.sv
// rtl/timer_apb_master.sv - APB4 requester driving the timer slave port from a cmd/rsp stream
//
// Purpose : accepts one register access at a time on the cmd_* stream, runs
//           the APB SETUP/ACCESS sequence with wait states and returns the
//           result on the rsp_* stream. Misaligned addresses are rejected
//           without a bus cycle.
// Config  : APB_MST_TIMEOUT_EN - when defined, an ACCESS phase that sees
//           TIMEOUT_CYCLES cycles without pready is aborted with
//           rsp_err=1 and rsp_timeout=1. Undefined: ACCESS waits forever.
// Ports   : clk, rst                      clock, async active-high reset
//           cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//           cmd_write/addr/wdata/strb     command payload
//           rsp_valid/rsp_ready           response handshake
//           rsp_rdata/rsp_err/rsp_timeout response payload
//           psel/penable/pwrite/paddr/pwdata/pstrb   APB requester outputs
//           prdata/pready/pslverr         APB completer inputs
module timer_apb_master
  import timer_apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W_DEF,
  parameter int unsigned DATA_W         = APB_DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int unsigned STRB_W = DATA_W / 8;

  apb_state_e state, state_nxt;

  logic              cmd_aligned;
  logic              timeout_hit;

  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_to_q;

  assign cmd_aligned = addr_aligned(cmd_addr[1:0]);

`ifdef APB_MST_TIMEOUT_EN
  timer_apb_mst_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == ST_SETUP),
    .count_en ((state == ST_ACCESS) && !pready),
    .expired  (timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nxt = cmd_aligned ? ST_SETUP : ST_RESP;
        end
      end
      ST_SETUP: begin
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready || timeout_hit) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus payload is captured only on an aligned accept and then left alone,
  // so it stays stable through SETUP/ACCESS and is retained afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            rsp_rdata_q <= '0;
            rsp_to_q    <= 1'b0;
            if (cmd_aligned) begin
              paddr_q   <= cmd_addr;
              pwrite_q  <= cmd_write;
              pstrb_q   <= cmd_write ? cmd_strb : '0;
              rsp_err_q <= 1'b0;
              // Reads leave the previous write data on pwdata.
              if (cmd_write) begin
                pwdata_q <= cmd_wdata;
              end
            end else begin
              rsp_err_q <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (pready) begin
            rsp_rdata_q <= (!pwrite_q && !pslverr) ? prdata : '0;
            rsp_err_q   <= pslverr;
            rsp_to_q    <= 1'b0;
          end else if (timeout_hit) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_to_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus control decodes straight from the state register so an async reset
  // drops psel/penable without waiting for a clock edge.
  assign psel      = (state == ST_SETUP) || (state == ST_ACCESS);
  assign penable   = (state == ST_ACCESS);
  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef APB_MST_TIMEOUT_EN
  assign rsp_timeout = rsp_to_q;
`else
  logic unused_rsp_to;
  assign unused_rsp_to = rsp_to_q;
  assign rsp_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_timer_apb_master.sv
// tb/tb_timer_apb_master.sv - directed self-checking bench for timer_apb_master
module tb_timer_apb_master;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TO_CYC = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                cmd_write = 1'b0;
  logic [ADDR_W-1:0]   cmd_addr = '0;
  logic [DATA_W-1:0]   cmd_wdata = '0;
  logic [DATA_W/8-1:0] cmd_strb = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic                rsp_timeout;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [ADDR_W-1:0]   paddr;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic [DATA_W-1:0]   prdata = '0;
  logic                pready = 1'b0;
  logic                pslverr = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  timer_apb_master #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic rsp_handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_clr"}, rsp_valid, 1'b0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_paddr", paddr, 13'h000);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_pstrb", pstrb, 4'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_cmd_ready", cmd_ready, 1'b1);

    // Zero-wait write; pready high during SETUP must be ignored.
    pready = 1'b1;
    send(1'b1, 13'h004, 32'hDEADBEEF, 4'hF);
    chk("wr_setup_psel", psel, 1'b1);
    chk("wr_setup_penable", penable, 1'b0);
    chk("wr_setup_cmd_ready", cmd_ready, 1'b0);
    chk("wr_paddr", paddr, 13'h004);
    chk("wr_pwrite", pwrite, 1'b1);
    chk("wr_pwdata", pwdata, 32'hDEADBEEF);
    chk("wr_pstrb", pstrb, 4'hF);
    tick();
    chk("wr_access_psel", psel, 1'b1);
    chk("wr_access_penable", penable, 1'b1);
    chk("wr_access_rsp_valid", rsp_valid, 1'b0);
    tick();
    chk("wr_rsp_valid", rsp_valid, 1'b1);
    chk("wr_rsp_err", rsp_err, 1'b0);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    chk("wr_resp_psel", psel, 1'b0);
    chk("wr_resp_penable", penable, 1'b0);
    chk("wr_paddr_kept", paddr, 13'h004);
    tick();
    chk("wr_rsp_hold", rsp_valid, 1'b1);
    rsp_handshake("wr");

    // Read with three wait states.
    pready = 1'b0;
    prdata = 32'h12345678;
    send(1'b0, 13'h010, 32'hFFFF0000, 4'hF);
    chk("rd_setup_psel", psel, 1'b1);
    chk("rd_pwrite", pwrite, 1'b0);
    chk("rd_pstrb_setup", pstrb, 4'h0);
    chk("rd_pwdata_kept", pwdata, 32'hDEADBEEF);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_penable", penable, 1'b1);
      chk("rd_wait_pstrb", pstrb, 4'h0);
      chk("rd_wait_paddr", paddr, 13'h010);
      chk("rd_wait_rsp_valid", rsp_valid, 1'b0);
      tick();
    end
    pready = 1'b1;
    chk("rd_last_penable", penable, 1'b1);
    tick();
    pready = 1'b0;
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("rd_rsp_err", rsp_err, 1'b0);
    chk("rd_resp_psel", psel, 1'b0);
    rsp_handshake("rd");

    // Read with slave error; a command waiting during RESP is held off.
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 32'hAAAA5555;
    send(1'b0, 13'h020, 32'h0, 4'h0);
    tick();
    tick();
    pslverr = 1'b0;
    chk("err_rsp_valid", rsp_valid, 1'b1);
    chk("err_rsp_err", rsp_err, 1'b1);
    chk("err_rsp_rdata", rsp_rdata, 32'h0);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 13'h008;
    cmd_wdata = 32'h11223344;
    cmd_strb  = 4'h3;
    chk("err_cmd_ready_resp", cmd_ready, 1'b0);
    tick();
    chk("err_blocked_psel", psel, 1'b0);
    chk("err_blocked_rsp", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("err_after_hs_psel", psel, 1'b0);
    chk("err_after_hs_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("wr2_setup_psel", psel, 1'b1);
    chk("wr2_paddr", paddr, 13'h008);
    chk("wr2_pstrb", pstrb, 4'h3);
    tick();
    tick();
    chk("wr2_rsp_valid", rsp_valid, 1'b1);
    chk("wr2_rsp_err", rsp_err, 1'b0);
    rsp_handshake("wr2");

    // Misaligned address: no bus cycle, immediate error response.
    send(1'b0, 13'h006, 32'h0, 4'h0);
    chk("mis_psel", psel, 1'b0);
    chk("mis_rsp_valid", rsp_valid, 1'b1);
    chk("mis_rsp_err", rsp_err, 1'b1);
    chk("mis_rsp_rdata", rsp_rdata, 32'h0);
    chk("mis_paddr_kept", paddr, 13'h008);
    rsp_handshake("mis");

    // Stalled ACCESS: timeout abort when enabled, indefinite wait otherwise.
    pready = 1'b0;
    send(1'b0, 13'h00C, 32'h0, 4'h0);
    tick();
    for (int i = 0; i < TO_CYC - 1; i++) begin
      chk("to_wait_penable", penable, 1'b1);
      tick();
    end
    chk("to_last_penable", penable, 1'b1);
    tick();
`ifdef APB_MST_TIMEOUT_EN
    chk("to_psel", psel, 1'b0);
    chk("to_penable", penable, 1'b0);
    chk("to_rsp_valid", rsp_valid, 1'b1);
    chk("to_rsp_timeout", rsp_timeout, 1'b1);
    chk("to_rsp_err", rsp_err, 1'b1);
    chk("to_rsp_rdata", rsp_rdata, 32'h0);
    rsp_handshake("to");
    send(1'b0, 13'h00C, 32'h0, 4'h0);
    tick();
`else
    for (int i = 0; i < 4; i++) begin
      chk("nto_psel", psel, 1'b1);
      chk("nto_penable", penable, 1'b1);
      chk("nto_rsp_valid", rsp_valid, 1'b0);
      chk("nto_rsp_timeout", rsp_timeout, 1'b0);
      tick();
    end
`endif

    // Asynchronous reset in ACCESS drops the bus before any clock edge.
    chk("ar_pre_penable", penable, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_psel", psel, 1'b0);
    chk("ar_penable", penable, 1'b0);
    chk("ar_rsp_valid", rsp_valid, 1'b0);
    chk("ar_paddr", paddr, 13'h000);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_cmd_ready", cmd_ready, 1'b1);
    chk("ar_idle_psel", psel, 1'b0);
    chk("ar_idle_rsp_valid", rsp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
